// File: rtl/clb_cluster.sv
// Logic cluster of NUM_LE K-input LUT/flop elements behind one serial configuration chain.
// Optional build macro CLB_CFG_READBACK_EN enables non-destructive chain rotation via cfg_loop.
module clb_cluster #(
  parameter int unsigned NUM_LE = 4,
  parameter int unsigned LUT_K  = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      config_en,
  input  logic                      config_data_in,
  input  logic                      cfg_loop,
  output logic                      config_data_out,
  output logic                      cfg_done,
  output logic                      cfg_err,
  input  logic [NUM_LE-1:0]         le_en,
  input  logic [NUM_LE-1:0]         le_srst,
  input  logic [NUM_LE*LUT_K-1:0]   le_in,
  output logic [NUM_LE-1:0]         le_out
);

  localparam int unsigned LutD     = 2**LUT_K;
  localparam int unsigned LE_CFG_W = LutD + 2 + LUT_K;
  localparam int unsigned CFG_LEN  = NUM_LE * LE_CFG_W;
  localparam int unsigned OffMode  = LutD;
  localparam int unsigned OffInit  = LutD + 1;
  localparam int unsigned OffFb    = LutD + 2;
  localparam int unsigned CntW     = $clog2(CFG_LEN + 2);

  typedef enum logic [1:0] {StUncfg, StLoad, StCfg, StErr} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CFG_LEN-1:0]  chain_q, chain_d;
  logic [NUM_LE-1:0]   flop_q, flop_d;
  logic [NUM_LE-1:0]   lut_out, stage, fb;
  logic [LUT_K-1:0]    idx;
  logic                shift, shift_in, out_en;

  assign shift = en & config_en;

`ifdef CLB_CFG_READBACK_EN
  assign shift_in = cfg_loop ? chain_q[CFG_LEN-1] : config_data_in;
`else
  logic unused_cfg_loop;
  assign unused_cfg_loop = cfg_loop;
  assign shift_in        = config_data_in;
`endif

  assign chain_d = shift ? {chain_q[CFG_LEN-2:0], shift_in} : chain_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (shift) begin
      if (state_q != StLoad) begin
        state_d = StLoad;
        cnt_d   = CntW'(1);
      end else if (cnt_q != CntW'(CFG_LEN + 1)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (state_q == StLoad && !config_en) begin
      state_d = (cnt_q == CntW'(CFG_LEN)) ? StCfg : StErr;
    end
  end

  assign out_en = (state_q == StCfg) & ~config_en;

  // Feedback is resolved by unrolling NUM_LE+1 evaluation passes instead of a structural loop;
  // any loop-free bitstream settles within that depth, and lut_out sees settled feedback.
  always_comb begin
    fb      = '0;
    stage   = '0;
    lut_out = '0;
    idx     = '0;
    for (int s = 0; s <= int'(NUM_LE); s++) begin
      for (int i = 0; i < int'(NUM_LE); i++) begin
        for (int j = 0; j < int'(LUT_K); j++) begin
          idx[j] = chain_q[i*LE_CFG_W + OffFb + j] ? fb[j % NUM_LE] : le_in[i*LUT_K + j];
        end
        lut_out[i] = chain_q[i*LE_CFG_W + int'(idx)];
        stage[i]   = out_en & (chain_q[i*LE_CFG_W + OffMode] ? flop_q[i] : lut_out[i]);
      end
      fb = stage;
    end
  end

  assign le_out = fb;

  always_comb begin
    flop_d = flop_q;
    for (int i = 0; i < int'(NUM_LE); i++) begin
      if (state_q != StCfg || le_srst[i]) begin
        flop_d[i] = chain_q[i*LE_CFG_W + OffInit];
      end else if (le_en[i]) begin
        flop_d[i] = lut_out[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StUncfg;
      cnt_q   <= '0;
      chain_q <= '0;
      flop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      flop_q  <= flop_d;
    end
  end

  assign config_data_out = chain_q[CFG_LEN-1];
  assign cfg_done        = (state_q == StCfg);
  assign cfg_err         = (state_q == StErr);

endmodule

// File: tb/tb_clb_cluster.sv
// Self-checking bench for clb_cluster: directed loads plus randomized user traffic
// checked against a queue-based behavioural model of the cluster.
module tb_clb_cluster;

  localparam int NUM_LE  = 4;
  localparam int LUT_K   = 4;
  localparam int W       = 22;
  localparam int CFG_LEN = 88;

  logic        clk = 1'b0;
  logic        nrst, en, config_en, config_data_in, cfg_loop;
  logic        config_data_out, cfg_done, cfg_err;
  logic [3:0]  le_en, le_srst, le_out;
  logic [15:0] le_in;

  always #5 clk = ~clk;

  clb_cluster #(.NUM_LE(NUM_LE), .LUT_K(LUT_K)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .config_en      (config_en),
    .config_data_in (config_data_in),
    .cfg_loop       (cfg_loop),
    .config_data_out(config_data_out),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err),
    .le_en          (le_en),
    .le_srst        (le_srst),
    .le_in          (le_in),
    .le_out         (le_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: queue index 0 is the chain MSB.
  typedef enum {MUncfg, MLoad, MCfg, MErr} mstate_e;
  bit      m_chain[$];
  int      m_cnt;
  mstate_e m_state;
  bit [3:0] m_flop;

  function automatic bit cbit(int le, int off);
    return m_chain[CFG_LEN-1-(le*W+off)];
  endfunction

  function automatic bit lut_eval(int le, bit [3:0] outs);
    bit [3:0] ix;
    for (int j = 0; j < LUT_K; j++)
      ix[j] = cbit(le, 18+j) ? outs[j % NUM_LE] : le_in[le*LUT_K+j];
    return cbit(le, int'(ix));
  endfunction

  function automatic bit [3:0] model_out();
    bit [3:0] o, n;
    o = '0;
    n = '0;
    if (m_state != MCfg || config_en) return 4'h0;
    repeat (NUM_LE + 1) begin
      for (int le = 0; le < NUM_LE; le++)
        n[le] = cbit(le, 16) ? m_flop[le] : lut_eval(le, o);
      o = n;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_chain = {};
    for (int k = 0; k < CFG_LEN; k++) m_chain.push_back(1'b0);
    m_cnt   = 0;
    m_state = MUncfg;
    m_flop  = '0;
  endtask

  task automatic model_edge();
    bit [3:0] o, nf;
    bit si;
    o  = model_out();
    nf = m_flop;
    for (int le = 0; le < NUM_LE; le++) begin
      if (m_state != MCfg || le_srst[le]) nf[le] = cbit(le, 17);
      else if (le_en[le])                 nf[le] = lut_eval(le, o);
    end
    m_flop = nf;
    si = config_data_in;
`ifdef CLB_CFG_READBACK_EN
    if (cfg_loop) si = m_chain[0];
`endif
    if (en && config_en) begin
      void'(m_chain.pop_front());
      m_chain.push_back(si);
      if (m_state != MLoad) begin
        m_state = MLoad;
        m_cnt   = 1;
      end else if (m_cnt < CFG_LEN + 1) begin
        m_cnt++;
      end
    end else if (m_state == MLoad && !config_en) begin
      m_state = (m_cnt == CFG_LEN) ? MCfg : MErr;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    #1;
    check({tag, " le_out"}, 32'(le_out), 32'(model_out()));
    check({tag, " cfg_done"}, 32'(cfg_done), 32'(m_state == MCfg));
    check({tag, " cfg_err"}, 32'(cfg_err), 32'(m_state == MErr));
    check({tag, " cdo"}, 32'(config_data_out), 32'(m_chain[0]));
  endtask

  task automatic do_reset();
    en = 0; config_en = 0; cfg_loop = 0; le_en = '0; le_srst = '0;
    nrst = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  task automatic shift_bits(bit [87:0] bs, int n);
    for (int k = 0; k < n; k++) begin
      en = 1'b1;
      config_en = 1'b1;
      config_data_in = (k < CFG_LEN) ? bs[CFG_LEN-1-k] : 1'b0;
      tick();
      if (k % 8 == 0) check_all("load");
    end
  endtask

  task automatic end_load();
    en = 1'b0;
    config_en = 1'b0;
    config_data_in = 1'b0;
    check_all("pre-end");
    tick();
    check_all("end");
  endtask

  task automatic random_cycles(int n);
    for (int c = 0; c < n; c++) begin
      le_in   = 16'($urandom);
      le_en   = 4'($urandom);
      le_srst = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      config_en = ($urandom_range(0, 7) == 0);
      check_all("rand");
      tick();
    end
    le_en = '0; le_srst = '0; config_en = 1'b0;
  endtask

  function automatic bit [21:0] make_le(bit [15:0] lut, bit mode, bit init, bit [3:0] fb);
    return {fb, init, mode, lut};
  endfunction

  function automatic bit [87:0] rand_bs();
    bit [3:0]  mode, fb;
    bit [87:0] bs;
    for (int i = 0; i < NUM_LE; i++) mode[i] = 1'($urandom);
    for (int i = 0; i < NUM_LE; i++) begin
      fb = 4'($urandom);
      // Only allow feedback that cannot close a combinational loop.
      for (int j = 0; j < LUT_K; j++)
        if (j >= i && !mode[j]) fb[j] = 1'b0;
      bs[i*W +: W] = make_le(16'($urandom), mode[i], 1'($urandom), fb);
    end
    return bs;
  endfunction

  bit [87:0] bs1, bsr;

  initial begin
    config_data_in = 0;
    le_in = '0;
    do_reset();
    check("rst le_out", 32'(le_out), 0);
    check("rst done", 32'(cfg_done), 0);

    bs1 = {make_le(16'h0000, 0, 0, 4'b0000), make_le(16'hAAAA, 0, 0, 4'b0001),
           make_le(16'h6996, 1, 1, 4'b0000), make_le(16'h8000, 0, 0, 4'b0000)};
    shift_bits(bs1, CFG_LEN);
    end_load();
    check("load done", 32'(cfg_done), 1);

    le_in = 16'h000F;
    check_all("and4 F");
    check("and4 F le0", 32'(le_out[0]), 1);
    check("fb le2", 32'(le_out[2]), 1);
    check("init le1", 32'(le_out[1]), 1);
    le_in = 16'h000E;
    check_all("and4 E");
    check("and4 E le0", 32'(le_out[0]), 0);
    check("fb le2 E", 32'(le_out[2]), 0);

    le_in = 16'h0030; le_en = 4'b0010;
    tick();
    le_en = '0;
    check("xor 3", 32'(le_out[1]), 0);
    le_in = 16'h0010; le_en = 4'b0010;
    tick();
    le_en = '0;
    check("xor 1", 32'(le_out[1]), 1);
    check_all("xor");
    le_in = 16'h0030; le_en = 4'b0010;
    tick();
    check("xor 3 again", 32'(le_out[1]), 0);
    le_srst = 4'b0010;
    tick();
    le_en = '0; le_srst = '0;
    check("srst prio", 32'(le_out[1]), 1);

    le_in = 16'h000F; config_en = 1'b1;
    tick();
    tick();
    check("gate le_out", 32'(le_out), 0);
    check("gate done", 32'(cfg_done), 1);
    config_en = 1'b0;
    check_all("ungate");

    random_cycles(60);

    shift_bits(bs1, CFG_LEN - 1);
    end_load();
    check("short err", 32'(cfg_err), 1);
    shift_bits(bs1, CFG_LEN + 1);
    end_load();
    check("long err", 32'(cfg_err), 1);
    check("long done", 32'(cfg_done), 0);

    shift_bits(bs1, 40);
    do_reset();
    shift_bits(bs1, CFG_LEN);
    end_load();
    check("reload done", 32'(cfg_done), 1);
    check("reload err", 32'(cfg_err), 0);

    for (int r = 0; r < 3; r++) begin
      bsr = rand_bs();
      shift_bits(bsr, CFG_LEN);
      end_load();
      random_cycles(30);
    end

`ifdef CLB_CFG_READBACK_EN
    cfg_loop = 1'b1;
    for (int k = 0; k < CFG_LEN; k++) begin
      en = 1'b1; config_en = 1'b1;
      #1;
      check("readback bit", 32'(config_data_out), 32'(bsr[CFG_LEN-1-k]));
      tick();
    end
    cfg_loop = 1'b0;
    end_load();
    check("rb done", 32'(cfg_done), 1);
    random_cycles(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
